// File: rtl/multiplier_if.sv
// ---------------------------------------------------------------------------
// multiplier_if
//   Operand/result bundle for the pipelined Q-format multiplier.
//   master : drives in_valid, A, B; observes out_valid, AB, ovf
//   slave  : the multiplier side (samples operands, returns the product)
//   Signals:
//     in_valid  1     A/B qualify this cycle
//     A, B      BITS  signed fixed-point operands
//     out_valid 1     AB/ovf carry a result this cycle
//     AB        BITS  signed fixed-point product
//     ovf       1     result left the BITS-bit range
// ---------------------------------------------------------------------------
interface multiplier_if #(
  parameter int BITS = 16
);
  logic            in_valid;
  logic [BITS-1:0] A;
  logic [BITS-1:0] B;
  logic            out_valid;
  logic [BITS-1:0] AB;
  logic            ovf;

  modport master (
    output in_valid,
    output A,
    output B,
    input  out_valid,
    input  AB,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  A,
    input  B,
    output out_valid,
    output AB,
    output ovf
  );
endinterface

// File: rtl/multiplier.sv
// ---------------------------------------------------------------------------
// multiplier
//   Two-stage pipelined signed fixed-point multiplier (Q8.8 by default,
//   0x0100 = 1.0). AB = round_half_up(A*B / 2^FRAC), range-checked against
//   the BITS-bit two's-complement range. Throughput one operation per clock,
//   no backpressure; a result appears after the second rising edge following
//   the cycle its operands were presented.
//
//   Build option (macro MULTIPLIER_SAT_EN):
//     defined   : out-of-range results clamp to the most positive / most
//                 negative BITS-bit value; ovf flags the clamp.
//     undefined : AB is the low BITS bits of the rounded value (wrap);
//                 ovf still reports that the value was out of range.
//
//   Parameters:
//     BITS  operand/result width (two's complement)
//     FRAC  fractional bits, 1 <= FRAC < BITS
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, clears every pipeline register
//     bus    multiplier_if.slave: in_valid/A/B in, out_valid/AB/ovf out
// ---------------------------------------------------------------------------
module multiplier #(
  parameter int BITS = 16,
  parameter int FRAC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  multiplier_if.slave bus
);

  // Working width: full product plus one guard bit so the rounding add
  // can never wrap, whatever the operands.
  localparam int W = 2 * BITS + 1;

  localparam logic signed [W-1:0] HALF_LSB =
    {{(W-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [W-1:0] MAX_R =
    {{(W-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_R =
    {{(W-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] SAT_POS = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] SAT_NEG = {1'b1, {(BITS-1){1'b0}}};

  // Stage 1: registered operands and qualifier
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic            v1_q, v1_d;

  // Stage 2: registered result
  logic [BITS-1:0] ab_q, ab_d;
  logic            ovf_q, ovf_d;
  logic            v2_q, v2_d;

  // Datapath between the stages
  logic signed [2*BITS-1:0] a_ext_s;
  logic signed [2*BITS-1:0] b_ext_s;
  logic signed [2*BITS-1:0] prod_s;
  logic signed [W-1:0]      prod_ext_s;
  logic signed [W-1:0]      rnd_s;
  logic signed [W-1:0]      r_s;
  logic                     over_hi_s;
  logic                     over_lo_s;

  // Stage-1 next state: capture the operands every cycle
  always_comb begin
    a_d  = bus.A;
    b_d  = bus.B;
    v1_d = bus.in_valid;
  end

  // Product, round-half-up, arithmetic shift and range check
  always_comb begin
    a_ext_s    = {{BITS{a_q[BITS-1]}}, a_q};
    b_ext_s    = {{BITS{b_q[BITS-1]}}, b_q};
    // Both operands are sign-extended to 2*BITS, so the low 2*BITS bits of
    // this product are the exact signed product.
    prod_s     = a_ext_s * b_ext_s;
    prod_ext_s = {prod_s[2*BITS-1], prod_s};
    // Adding half an output LSB then flooring via >>> rounds ties upward.
    rnd_s      = prod_ext_s + HALF_LSB;
    r_s        = rnd_s >>> FRAC;
    over_hi_s  = (r_s > MAX_R);
    over_lo_s  = (r_s < MIN_R);
  end

  // Stage-2 next state: new result on a valid slot, otherwise hold AB/ovf
  always_comb begin
    ab_d  = ab_q;
    ovf_d = ovf_q;
    v2_d  = 1'b0;
    if (v1_q) begin
      v2_d  = 1'b1;
      ovf_d = over_hi_s | over_lo_s;
`ifdef MULTIPLIER_SAT_EN
      if (over_hi_s) begin
        ab_d = SAT_POS;
      end else if (over_lo_s) begin
        ab_d = SAT_NEG;
      end else begin
        ab_d = r_s[BITS-1:0];
      end
`else
      ab_d = r_s[BITS-1:0];
`endif
    end else begin
      v2_d  = 1'b0;
      ab_d  = ab_q;
      ovf_d = ovf_q;
    end
  end

  // Stage-1 pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= {BITS{1'b0}};
      b_q  <= {BITS{1'b0}};
      v1_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      v1_q <= v1_d;
    end
  end

  // Stage-2 pipeline registers (drive the outputs directly)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_q  <= {BITS{1'b0}};
      ovf_q <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      ab_q  <= ab_d;
      ovf_q <= ovf_d;
      v2_q  <= v2_d;
    end
  end

  // Registered outputs onto the interface
  always_comb begin
    bus.out_valid = v2_q;
    bus.AB        = ab_q;
    bus.ovf       = ovf_q;
  end

  // Unused when the saturation build is off
  logic unused_s;
  always_comb begin
    unused_s = ^{SAT_POS, SAT_NEG};
  end

endmodule

// File: tb/tb_multiplier.sv
// ---------------------------------------------------------------------------
// tb_multiplier
//   Directed bench for multiplier (BITS=16, FRAC=8). Expected values are
//   hand-computed Q8.8 products; the saturating and wrapping builds differ
//   only in the overflowing vectors.
// ---------------------------------------------------------------------------
module tb_multiplier;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

`ifdef MULTIPLIER_SAT_EN
  localparam logic [15:0] EXP_7F00x0200 = 16'h7FFF;
  localparam logic [15:0] EXP_8000x0200 = 16'h8000;
  localparam logic [15:0] EXP_8000x8000 = 16'h7FFF;
  localparam logic [15:0] EXP_8000xFF00 = 16'h7FFF;
`else
  localparam logic [15:0] EXP_7F00x0200 = 16'hFE00;
  localparam logic [15:0] EXP_8000x0200 = 16'h0000;
  localparam logic [15:0] EXP_8000x8000 = 16'h0000;
  localparam logic [15:0] EXP_8000xFF00 = 16'h8000;
`endif

  multiplier_if #(.BITS(16)) bus ();

  multiplier #(.BITS(16), .FRAC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated operation: drive at a falling edge, result after two rising edges
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_ab, input logic exp_ovf);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".early_valid"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, ".AB"}, {16'd0, bus.AB}, {16'd0, exp_ab});
    chk({tag, ".ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
    @(negedge clk);
    chk({tag, ".bubble_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, ".hold_AB"}, {16'd0, bus.AB}, {16'd0, exp_ab});
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.A        = 16'h0000;
    bus.B        = 16'h0000;

    repeat (2) @(negedge clk);
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.AB", {16'd0, bus.AB}, 32'd0);
    chk("rst.ovf", {31'd0, bus.ovf}, 32'd0);
    rst_n = 1'b1;

    // Basic products
    run_op("one_x_one",  16'h0100, 16'h0100, 16'h0100, 1'b0);
    run_op("1p5_x_m1",   16'h0180, 16'hFF00, 16'hFE80, 1'b0);
    run_op("max_x_one",  16'h7FFF, 16'h0100, 16'h7FFF, 1'b0);
    run_op("zero_x_min", 16'h0000, 16'h8000, 16'h0000, 1'b0);

    // Rounding: ties go toward +inf
    run_op("rnd_tie_up",  16'h0001, 16'h0080, 16'h0001, 1'b0);
    run_op("rnd_below",   16'h0001, 16'h007F, 16'h0000, 1'b0);
    run_op("rnd_neg_tie", 16'hFFFF, 16'h0080, 16'h0000, 1'b0);

    // Overflow
    run_op("ovf_pos",       16'h7F00, 16'h0200, EXP_7F00x0200, 1'b1);
    run_op("ovf_neg",       16'h8000, 16'h0200, EXP_8000x0200, 1'b1);
    run_op("ovf_min_x_min", 16'h8000, 16'h8000, EXP_8000x8000, 1'b1);
    run_op("ovf_min_x_m1",  16'h8000, 16'hFF00, EXP_8000xFF00, 1'b1);
    run_op("after_ovf",     16'h0200, 16'h0080, 16'h0100, 1'b0);

    // Back-to-back stream of four
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 16'h0100; bus.B = 16'h0100;
    @(negedge clk);
    bus.A = 16'h0200; bus.B = 16'h0200;
    @(negedge clk);
    chk("str0.valid", {31'd0, bus.out_valid}, 32'd1);
    chk("str0.AB", {16'd0, bus.AB}, 32'h0100);
    bus.A = 16'hFF00; bus.B = 16'h0300;
    @(negedge clk);
    chk("str1.valid", {31'd0, bus.out_valid}, 32'd1);
    chk("str1.AB", {16'd0, bus.AB}, 32'h0400);
    bus.A = 16'h0000; bus.B = 16'h0500;
    @(negedge clk);
    chk("str2.valid", {31'd0, bus.out_valid}, 32'd1);
    chk("str2.AB", {16'd0, bus.AB}, 32'hFD00);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("str3.valid", {31'd0, bus.out_valid}, 32'd1);
    chk("str3.AB", {16'd0, bus.AB}, 32'h0000);
    chk("str3.ovf", {31'd0, bus.ovf}, 32'd0);
    @(negedge clk);
    chk("str_end.valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-flight: two valids issued, then async reset between edges
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 16'h0200; bus.B = 16'h0200;
    @(negedge clk);
    bus.A = 16'h0300; bus.B = 16'h0100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst.valid", {31'd0, bus.out_valid}, 32'd1);
    chk("pre_rst.AB", {16'd0, bus.AB}, 32'h0400);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst.AB", {16'd0, bus.AB}, 32'd0);
    chk("async_rst.ovf", {31'd0, bus.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst.valid", {31'd0, bus.out_valid}, 32'd0);
      chk("post_rst.AB", {16'd0, bus.AB}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
